game_logic: RTL and testbench

GAME_LOGIC -- requirements
Module: game_logic

---
 rtl/game_logic_if.sv | 26 ++
 rtl/game_logic.sv | 137 +++++++++++++
 tb/tb_game_logic.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/game_logic_if.sv
// Bundles the game control inputs and the scene/score outputs of game_logic.
interface game_logic_if;
    logic       frame_tick;
    logic       start;
    logic       flap;
    logic [9:0] plane_y;
    logic [9:0] mountain1_x;
    logic [9:0] mountain1_y;
    logic [9:0] mountain2_x;
    logic [9:0] mountain2_y;
    logic [9:0] lava_x;
    logic       game_over;
    logic [7:0] score;

    modport master (
        output frame_tick, start, flap,
        input  plane_y, mountain1_x, mountain1_y, mountain2_x, mountain2_y,
        input  lava_x, game_over, score
    );

    modport slave (
        input  frame_tick, start, flap,
        output plane_y, mountain1_x, mountain1_y, mountain2_x, mountain2_y,
        output lava_x, game_over, score
    );
endinterface

// File: rtl/game_logic.sv
// Side-scrolling plane game: plane, two scrolling mountains, a lava block,
// score keeping, collision detection and an IDLE/PLAY/OVER state machine.
module game_logic (
    input  logic         clk,
    input  logic         reset,
    game_logic_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, PLAY, OVER} state_t;

    state_t     state_reg;
    logic [7:0] lfsr_reg;
    logic [7:0] lfsr_next;
    logic       check_reg;
    logic       game_over_reg;
    logic [9:0] plane_y_reg;
    logic [9:0] plane_y_next;
    logic [9:0] lava_x_reg;
    logic [9:0] lava_x_next;
    logic [7:0] score_reg;
    logic [7:0] score_next;
    logic [8:0] score_sum;
    logic       wrap [2];
    logic       mtn_hit [2];
    logic [9:0] mtn_x [2];
    logic [9:0] mtn_y [2];
    logic       floor_hit;
    logic       lava_hit;
    logic       collide;
    logic       reload;
    logic       advance;

    // Leaving OVER restores the start-of-game picture; LFSR keeps running.
    assign reload  = (state_reg == OVER) && bus.start;
    assign collide = floor_hit | lava_hit | mtn_hit[0] | mtn_hit[1];
    // A detected collision wins over a tick landing in the same cycle.
    assign advance = (state_reg == PLAY) && bus.frame_tick && !(check_reg && collide);

    assign lfsr_next = {lfsr_reg[6:0], lfsr_reg[7] ^ lfsr_reg[5] ^ lfsr_reg[4] ^ lfsr_reg[3]};

    assign plane_y_next = bus.flap ? ((plane_y_reg < 10'd3)   ? 10'd0   : plane_y_reg - 10'd3)
                                   : ((plane_y_reg > 10'd462) ? 10'd464 : plane_y_reg + 10'd2);
    assign lava_x_next  = (lava_x_reg < 10'd4) ? 10'd640 : lava_x_reg - 10'd4;

    assign score_sum  = {1'b0, score_reg} + {8'd0, wrap[0]} + {8'd0, wrap[1]};
    assign score_next = score_sum[8] ? 8'd255 : score_sum[7:0];

    assign floor_hit = (plane_y_reg == 10'd464);
    assign lava_hit  = (lava_x_reg >= 10'd64) && (lava_x_reg <= 10'd96) &&
                       (plane_y_reg >= 10'd84) && (plane_y_reg <= 10'd116);

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_mtn
            localparam logic [9:0] X_INIT = (gi == 0) ? 10'd400 : 10'd720;
            localparam logic [9:0] Y_INIT = (gi == 0) ? 10'd320 : 10'd360;
            logic [9:0] x_reg;
            logic [9:0] y_reg;

            assign wrap[gi]    = (x_reg < 10'd27);
            assign mtn_hit[gi] = (x_reg >= 10'd55) && (x_reg <= 10'd121) &&
                                 ((plane_y_reg + 10'd16) >= y_reg);
            assign mtn_x[gi]   = x_reg;
            assign mtn_y[gi]   = y_reg;

            // Mountain scrolls left and respawns off-screen right at a random height.
            always_ff @(posedge clk) begin
                if (reset || reload) begin
                    x_reg <= X_INIT;
                    y_reg <= Y_INIT;
                end else if (advance) begin
                    if (wrap[gi]) begin
                        x_reg <= 10'd665;
                        y_reg <= 10'd280 + {3'b000, lfsr_reg[6:0]};
                    end else begin
                        x_reg <= x_reg - 10'd2;
                    end
                end
            end
        end
    endgenerate

    // Plane, lava and score move together on each frame tick during play.
    always_ff @(posedge clk) begin
        if (reset || reload) begin
            plane_y_reg <= 10'd232;
            lava_x_reg  <= 10'd600;
            score_reg   <= 8'd0;
        end else if (advance) begin
            plane_y_reg <= plane_y_next;
            lava_x_reg  <= lava_x_next;
            score_reg   <= score_next;
        end
    end

    // Game state machine; collisions are judged the cycle after an update.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            game_over_reg <= 1'b0;
            check_reg     <= 1'b0;
            lfsr_reg      <= 8'hA5;
        end else begin
            lfsr_reg  <= lfsr_next;
            check_reg <= advance;
            case (state_reg)
                IDLE: begin
                    if (bus.start) state_reg <= PLAY;
                end
                PLAY: begin
                    if (check_reg && collide) begin
                        state_reg     <= OVER;
                        game_over_reg <= 1'b1;
                    end
                end
                OVER: begin
                    if (bus.start) begin
                        state_reg     <= IDLE;
                        game_over_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg     <= IDLE;
                    game_over_reg <= 1'b0;
                end
            endcase
        end
    end

    assign bus.plane_y     = plane_y_reg;
    assign bus.mountain1_x = mtn_x[0];
    assign bus.mountain1_y = mtn_y[0];
    assign bus.mountain2_x = mtn_x[1];
    assign bus.mountain2_y = mtn_y[1];
    assign bus.lava_x      = lava_x_reg;
    assign bus.game_over   = game_over_reg;
    assign bus.score       = score_reg;
endmodule

// File: tb/tb_game_logic.sv
// Self-checking bench for game_logic: directed scenarios plus random play,
// all compared each cycle against a behavioural game model.
module tb_game_logic;
    logic clk = 1'b0;
    logic reset = 1'b0;
    game_logic_if bus();

    game_logic dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model of the game
    localparam int M_IDLE = 0;
    localparam int M_PLAY = 1;
    localparam int M_OVER = 2;
    int       m_mode;
    bit       m_pending;
    int       m_py, m_lx, m_score;
    int       m_mx [2];
    int       m_my [2];
    bit       m_go;
    bit [7:0] m_lfsr;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_defaults();
        m_py = 232; m_lx = 600; m_score = 0; m_go = 0;
        m_mx[0] = 400; m_my[0] = 320;
        m_mx[1] = 720; m_my[1] = 360;
    endtask

    function automatic bit model_hit();
        bit hit = (m_py == 464);
        for (int i = 0; i < 2; i++)
            if (m_mx[i] >= 55 && m_mx[i] <= 121 && m_py + 16 >= m_my[i]) hit = 1;
        if (m_lx >= 64 && m_lx <= 96 && m_py >= 84 && m_py <= 116) hit = 1;
        return hit;
    endfunction

    task automatic model_step(input bit t, input bit s, input bit f, input bit r);
        bit [7:0] nl;
        bit       was_pending;
        nl = {m_lfsr[6:0], ^(m_lfsr & 8'hB8)};
        was_pending = m_pending;
        m_pending = 0;
        if (r) begin
            model_defaults();
            m_mode = M_IDLE;
            m_lfsr = 8'hA5;
            return;
        end
        case (m_mode)
            M_IDLE: if (s) m_mode = M_PLAY;
            M_PLAY: begin
                if (was_pending && model_hit()) begin
                    m_mode = M_OVER;
                    m_go = 1;
                end else if (t) begin
                    int wraps = 0;
                    m_py = f ? ((m_py - 3 < 0) ? 0 : m_py - 3)
                             : ((m_py + 2 > 464) ? 464 : m_py + 2);
                    for (int i = 0; i < 2; i++) begin
                        if (m_mx[i] < 27) begin
                            m_mx[i] = 665;
                            m_my[i] = 280 + (m_lfsr % 128);
                            wraps++;
                        end else begin
                            m_mx[i] -= 2;
                        end
                    end
                    m_lx = (m_lx < 4) ? 640 : m_lx - 4;
                    m_score = (m_score + wraps > 255) ? 255 : m_score + wraps;
                    m_pending = 1;
                end
            end
            default: if (s) begin
                model_defaults();
                m_mode = M_IDLE;
            end
        endcase
        m_lfsr = nl;
    endtask

    task automatic compare_all();
        check("plane_y",     bus.plane_y,     m_py);
        check("mountain1_x", bus.mountain1_x, m_mx[0]);
        check("mountain1_y", bus.mountain1_y, m_my[0]);
        check("mountain2_x", bus.mountain2_x, m_mx[1]);
        check("mountain2_y", bus.mountain2_y, m_my[1]);
        check("lava_x",      bus.lava_x,      m_lx);
        check("game_over",   bus.game_over,   m_go);
        check("score",       bus.score,       m_score);
    endtask

    // One clock cycle with the given inputs, then model update and compare.
    task automatic cyc(input bit t, input bit s, input bit f, input bit r);
        bus.frame_tick = t; bus.start = s; bus.flap = f; reset = r;
        @(posedge clk);
        model_step(t, s, f, r);
        #1;
        compare_all();
    endtask

    // n frame ticks, each followed by a quiet cycle for the collision check.
    task automatic ticks(input int n, input bit f);
        for (int i = 0; i < n; i++) begin
            cyc(1, 0, f, 0);
            cyc(0, 0, f, 0);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_plane_y"}, bus.plane_y, 232);
        check({tag, "_m1x"},     bus.mountain1_x, 400);
        check({tag, "_m1y"},     bus.mountain1_y, 320);
        check({tag, "_m2x"},     bus.mountain2_x, 720);
        check({tag, "_m2y"},     bus.mountain2_y, 360);
        check({tag, "_lava_x"},  bus.lava_x, 600);
        check({tag, "_score"},   bus.score, 0);
        check({tag, "_go"},      bus.game_over, 0);
    endtask

    initial begin
        bus.frame_tick = 0; bus.start = 0; bus.flap = 0;
        m_mode = M_IDLE; m_pending = 0; m_lfsr = 8'hA5;
        model_defaults();

        // Idle with ticks: nothing moves
        cyc(0, 0, 0, 1);
        check_reset_values("rst");
        for (int i = 0; i < 5; i++) cyc(1, 0, 1, 0);
        check_reset_values("idle");

        // Start with a coincident tick: no update that cycle; then 10 falling ticks
        cyc(1, 1, 0, 0);
        check("start_tick_plane_y", bus.plane_y, 232);
        ticks(10, 0);
        check("fall10_plane_y", bus.plane_y, 252);
        check("fall10_m1x", bus.mountain1_x, 380);
        check("fall10_lava", bus.lava_x, 560);
        check("fall10_go", bus.game_over, 0);

        // Climb to the ceiling and past the first mountain wrap
        cyc(0, 0, 0, 1);
        cyc(0, 1, 0, 0);
        ticks(188, 1);
        check("climb_plane_y", bus.plane_y, 0);
        check("climb_go", bus.game_over, 0);
        check("climb_m1x", bus.mountain1_x, 665);
        check("climb_m1y_range", (bus.mountain1_y >= 280 && bus.mountain1_y <= 407) ? 1 : 0, 1);
        check("climb_score", bus.score, 1);

        // Fall to the floor: game_over two cycles after the last tick
        cyc(0, 0, 0, 1);
        cyc(0, 1, 0, 0);
        ticks(115, 0);
        cyc(1, 0, 0, 0);
        check("floor_plane_y", bus.plane_y, 464);
        check("floor_go_early", bus.game_over, 0);
        cyc(0, 0, 0, 0);
        check("floor_go", bus.game_over, 1);
        ticks(10, 1);
        check("over_plane_y", bus.plane_y, 464);
        check("over_m1x", bus.mountain1_x, 168);
        check("over_lava", bus.lava_x, 136);
        check("over_go", bus.game_over, 1);

        // OVER -> IDLE restores the start picture, next start plays again
        cyc(0, 1, 0, 0);
        check_reset_values("restart");
        cyc(0, 1, 0, 0);
        ticks(1, 0);
        check("replay_plane_y", bus.plane_y, 234);

        // Reset mid-game with a coincident tick
        ticks(5, 1);
        cyc(1, 0, 1, 1);
        check_reset_values("midrst");

        // Long climb at the ceiling: score saturates at 255
        cyc(0, 1, 0, 0);
        for (int i = 0; i < 41500; i++) cyc(1, 0, 1, 0);
        check("sat_score", bus.score, 255);
        check("sat_go", bus.game_over, 0);

        // Random play against the model
        cyc(0, 0, 0, 1);
        for (int i = 0; i < 4000; i++) begin
            cyc(($urandom_range(3) == 0), ($urandom_range(40) == 0),
                $urandom_range(1), ($urandom_range(300) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
